spi_host_queue: RTL and testbench

Buffered transfer sequencer that sits directly upstream of `spi_topmodule` and drives its `control`/`datain` inputs while consuming its `dataout`/`status` outputs. The host pushes 32-bit MOSI words into a TX FIFO. The block runs one SPI word per entry and pushes each received MISO word into an RX FIFO. It applies backpressure instead of dropping data, and flags a hung core with a timeout.

---
 rtl/spi_host_pkg.sv | 18 +
 rtl/sync_fifo.sv | 50 +++++
 rtl/spi_host_queue.sv | 141 ++++++++++++++
 tb/tb_spi_host_queue.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_host_pkg.sv
// Shared constants and FSM state type for the buffered SPI transfer sequencer.
package spi_host_pkg;

  localparam int WORD_W        = 32;
  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int STAT_BUSY     = 0;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_BUSY,
    WAIT_DONE,
    STORE,
    GAP_WAIT
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count; used for both TX and RX queues.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == FULL_LEVEL);
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is legal only when a pop frees the slot in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      level <= level + (AW+1)'(1);
      else if (do_pop && !do_push) level <= level - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/spi_host_queue.sv
// Buffered transfer sequencer: feeds queued MOSI words to an SPI core one at a time,
// collects MISO words into an RX queue, and flags a core that never goes busy.
module spi_host_queue
  import spi_host_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int GAP     = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  input  logic [31:0]             tx_data,
  input  logic [1:0]              mode,
  output logic                    rx_valid,
  input  logic                    rx_ready,
  output logic [31:0]             rx_data,
  output logic [$clog2(DEPTH):0]  tx_level,
  output logic [$clog2(DEPTH):0]  rx_level,
  output logic                    err,
  output logic [31:0]             spi_control,
  output logic [31:0]             spi_datain,
  input  logic [31:0]             spi_dataout,
  input  logic [31:0]             spi_status
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
  // Enable stays low through GAP_WAIT, IDLE and LOAD, so GAP_WAIT itself is one cycle shorter.
  localparam logic [7:0] GAP_HOLD = (GAP > 1) ? 8'(GAP - 1) : 8'd1;

  state_t            state;
  state_t            state_next;
  logic [7:0]        cnt;
  logic              tx_full;
  logic              tx_empty;
  logic              rx_full;
  logic              rx_empty;
  logic              tx_pop;
  logic              rx_push;
  logic              busy;
  logic              timed_out;
  logic [WORD_W-1:0] tx_head;
  logic              unused_status;

  assign busy          = spi_status[STAT_BUSY];
  assign unused_status = ^spi_status[WORD_W-1:1];
  assign timed_out     = (state == WAIT_BUSY) && !busy && (cnt == TIMEOUT_CNT);
  assign tx_ready      = !tx_full;
  assign rx_valid      = !rx_empty;

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(WORD_W)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_valid && tx_ready),
    .wdata (tx_data),
    .pop   (tx_pop),
    .rdata (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .level (tx_level)
  );

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(WORD_W)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .wdata (spi_dataout),
    .pop   (rx_ready && rx_valid),
    .rdata (rx_data),
    .full  (rx_full),
    .empty (rx_empty),
    .level (rx_level)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Only one word is ever in flight, so checking RX space before LOAD guarantees STORE never overflows.
  always_comb begin
    state_next = state;
    tx_pop     = 1'b0;
    rx_push    = 1'b0;
    case (state)
      IDLE:      if (!tx_empty && !rx_full) state_next = LOAD;
      LOAD: begin
        tx_pop     = 1'b1;
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (busy)           state_next = WAIT_DONE;
        else if (timed_out) state_next = GAP_WAIT;
      end
      WAIT_DONE: if (!busy) state_next = STORE;
      STORE: begin
        rx_push    = 1'b1;
        state_next = GAP_WAIT;
      end
      GAP_WAIT:  if (cnt >= GAP_HOLD) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // The shared counter times WAIT_BUSY from the LOAD edge and the idle gap from STORE or abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      spi_control <= '0;
      spi_datain  <= '0;
      err         <= 1'b0;
      cnt         <= '0;
    end else begin
      case (state)
        LOAD: begin
          spi_datain                       <= tx_head;
          spi_control                      <= '0;
          spi_control[CTRL_EN]             <= 1'b1;
          spi_control[CTRL_MODE_LSB +: 2]  <= mode;
          cnt                              <= 8'd1;
        end
        WAIT_BUSY: begin
          if (timed_out) begin
            err                  <= 1'b1;
            spi_control[CTRL_EN] <= 1'b0;
            cnt                  <= 8'd1;
          end else if (!busy) begin
            cnt <= cnt + 8'd1;
          end
        end
        STORE: begin
          spi_control[CTRL_EN] <= 1'b0;
          cnt                  <= 8'd1;
        end
        GAP_WAIT: cnt <= cnt + 8'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_host_queue.sv
// Randomized bench for spi_host_queue with a cycle-level SPI core model and queue-based reference.
module tb_spi_host_queue;

  localparam int DEPTH   = 8;
  localparam int GAP     = 2;
  localparam int TIMEOUT = 255;
  localparam int LW      = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic [31:0]   tx_data = '0;
  logic [1:0]    mode = 2'b00;
  logic          rx_valid;
  logic          rx_ready = 1'b0;
  logic [31:0]   rx_data;
  logic [LW-1:0] tx_level;
  logic [LW-1:0] rx_level;
  logic          err;
  logic [31:0]   spi_control;
  logic [31:0]   spi_datain;
  logic [31:0]   spi_dataout;
  logic [31:0]   spi_status;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // core model configuration
  int          core_delay = 3;
  int          core_hold = 64;
  bit          core_random = 1'b0;
  bit          core_fixed = 1'b0;
  logic [31:0] core_resp_fixed = '0;
  int          core_dead = 0;
  int          core_fall_cyc = 0;

  // reference queues
  logic [31:0] exp_rx[$];
  logic [31:0] tx_hist[$];
  logic [31:0] rise_ctrl[$];
  logic [31:0] rise_data[$];
  int          rise_cyc[$];
  int          gaps[$];

  bit          stall_seen = 1'b0;
  logic [31:0] stall_level = '0;

  spi_host_queue #(.DEPTH(DEPTH), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .mode        (mode),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .tx_level    (tx_level),
    .rx_level    (rx_level),
    .err         (err),
    .spi_control (spi_control),
    .spi_datain  (spi_datain),
    .spi_dataout (spi_dataout),
    .spi_status  (spi_status)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // SPI core model: goes busy a few cycles after enable rises, then returns a response word.
  initial begin : core_model
    int          phase;
    int          count;
    bit          prev_en;
    bit          aborted;
    logic [31:0] resp;
    phase = 0; count = 0; prev_en = 1'b0; aborted = 1'b0; resp = '0;
    spi_status  = '0;
    spi_dataout = '0;
    forever begin
      tick();
      case (phase)
        0: begin
          if (spi_control[0] && !prev_en) begin
            if (core_dead > 0) begin
              core_dead--;
            end else begin
              count   = core_random ? int'($urandom_range(1, 5)) : core_delay;
              aborted = 1'b0;
              phase   = 1;
            end
          end
        end
        1: begin
          if (!spi_control[0]) begin
            phase = 0;
          end else begin
            count--;
            if (count == 0) begin
              resp        = core_fixed ? core_resp_fixed : $urandom;
              spi_dataout = resp;
              spi_status  = ($urandom & ~32'h1) | 32'h1;
              count       = core_random ? int'($urandom_range(1, 20)) : core_hold;
              phase       = 2;
            end
          end
        end
        default: begin
          if (!spi_control[0]) aborted = 1'b1;
          count--;
          if (count == 0) begin
            spi_status    = $urandom & ~32'h1;
            core_fall_cyc = cyc;
            phase         = 0;
            if (!aborted) exp_rx.push_back(resp);
          end
        end
      endcase
      prev_en = spi_control[0];
    end
  end

  // Records every enable rise with its control word, data word and preceding low-time.
  initial begin : monitor
    bit prev_en;
    int low_run;
    prev_en = 1'b0;
    low_run = 0;
    forever begin
      tick();
      if (spi_control[0] && !prev_en) begin
        rise_ctrl.push_back(spi_control);
        rise_data.push_back(spi_datain);
        rise_cyc.push_back(cyc);
        gaps.push_back(low_run);
      end
      low_run = spi_control[0] ? 0 : low_run + 1;
      prev_en = spi_control[0];
    end
  end

  task automatic clearHist();
    tx_hist.delete();
    rise_ctrl.delete();
    rise_data.delete();
    rise_cyc.delete();
    gaps.delete();
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_rx.delete();
    clearHist();
  endtask

  task automatic applyStimulus(input logic [31:0] data, input logic [1:0] m);
    bit acc;
    acc      = 1'b0;
    tx_valid = 1'b1;
    tx_data  = data;
    mode     = m;
    for (int k = 0; k < 2000 && !acc; k++) begin
      acc = tx_ready;
      if (!tx_ready && !stall_seen) begin
        stall_seen  = 1'b1;
        stall_level = 32'(tx_level);
      end
      tick();
    end
    tx_valid = 1'b0;
    if (acc) tx_hist.push_back(data);
    else     checkOutput("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitRx(input int bound, output bit ok);
    for (int k = 0; k < bound && !rx_valid; k++) tick();
    ok = rx_valid;
  endtask

  task automatic drainRx(input string tag, input int n);
    bit ok;
    for (int i = 0; i < n; i++) begin
      waitRx(3000, ok);
      if (!ok) begin
        checkOutput($sformatf("%s_rx_timeout", tag), 32'd0, 32'd1);
        return;
      end
      if (exp_rx.size() == 0) begin
        checkOutput($sformatf("%s_rx_unexpected", tag), rx_data, 32'hxxxxxxxx);
      end else begin
        checkOutput($sformatf("%s_rx%0d", tag, i), rx_data, exp_rx.pop_front());
      end
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
    end
  endtask

  task automatic checkOrder(input string tag, input int n);
    checkOutput($sformatf("%s_rises", tag), 32'(rise_data.size()), 32'(n));
    for (int i = 0; i < n && i < rise_data.size() && i < tx_hist.size(); i++)
      checkOutput($sformatf("%s_datain%0d", tag, i), rise_data[i], tx_hist[i]);
  endtask

  initial begin : main
    bit          ok;
    logic [31:0] w;
    int          k;

    doReset();

    // reset values
    checkOutput("rst_tx_ready", 32'(tx_ready), 32'd1);
    checkOutput("rst_rx_valid", 32'(rx_valid), 32'd0);
    checkOutput("rst_rx_data", rx_data, 32'd0);
    checkOutput("rst_tx_level", 32'(tx_level), 32'd0);
    checkOutput("rst_rx_level", 32'(rx_level), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_control", spi_control, 32'd0);
    checkOutput("rst_datain", spi_datain, 32'd0);

    // single word, fixed core timing and response
    core_fixed = 1'b1; core_resp_fixed = 32'h88885678;
    core_delay = 3; core_hold = 64; core_random = 1'b0;
    applyStimulus(32'h87654321, 2'b00);
    tick();
    checkOutput("t1_en_early", 32'(spi_control[0]), 32'd0);
    tick();
    checkOutput("t1_control", spi_control, 32'h1);
    checkOutput("t1_datain", spi_datain, 32'h87654321);
    waitRx(300, ok);
    checkOutput("t1_rx_seen", 32'(ok), 32'd1);
    checkOutput("t1_rx_latency", 32'(cyc - core_fall_cyc), 32'd2);
    checkOutput("t1_en_cleared", 32'(spi_control[0]), 32'd0);
    checkOutput("t1_rx_level", 32'(rx_level), 32'd1);
    drainRx("t1", 1);
    core_fixed = 1'b0;

    // four back-to-back words in mode 01 with random core timing
    clearHist();
    core_random = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus($urandom, 2'b01);
    drainRx("t2", 4);
    checkOrder("t2", 4);
    for (int i = 0; i < rise_ctrl.size(); i++)
      checkOutput($sformatf("t2_ctrl%0d", i), rise_ctrl[i], 32'h3);
    for (int i = 1; i < gaps.size(); i++)
      checkOutput($sformatf("t2_gap%0d", i), 32'(gaps[i]), 32'(GAP + 1));

    // RX backpressure: ten words with the host not popping
    clearHist();
    core_random = 1'b0; core_delay = 3; core_hold = 10;
    stall_seen = 1'b0;
    for (int i = 0; i < 10; i++) applyStimulus($urandom, 2'($urandom_range(0, 3)));
    checkOutput("t3_stall_seen", 32'(stall_seen), 32'd1);
    checkOutput("t3_stall_level", stall_level, 32'(DEPTH));
    k = 0;
    while (rx_level != LW'(DEPTH) && k < 3000) begin tick(); k++; end
    for (int i = 0; i < 40; i++) tick();
    checkOutput("t3_rx_full", 32'(rx_level), 32'(DEPTH));
    checkOutput("t3_tx_left", 32'(tx_level), 32'd2);
    checkOutput("t3_en_idle", 32'(spi_control[0]), 32'd0);
    checkOutput("t3_rises_stalled", 32'(rise_data.size()), 32'(DEPTH));
    drainRx("t3", 10);
    checkOrder("t3", 10);

    // dead core: first word times out, second runs normally
    clearHist();
    core_dead = 1; core_delay = 2; core_hold = 5;
    applyStimulus($urandom, 2'b00);
    applyStimulus($urandom, 2'b00);
    k = 0;
    while (!err && k < 1000) begin tick(); k++; end
    checkOutput("t4_err_set", 32'(err), 32'd1);
    if (rise_cyc.size() > 0)
      checkOutput("t4_err_delay", 32'(cyc - rise_cyc[0]), 32'(TIMEOUT));
    checkOutput("t4_en_cleared", 32'(spi_control[0]), 32'd0);
    checkOutput("t4_rx_unchanged", 32'(rx_level), 32'd0);
    drainRx("t4", 1);
    checkOutput("t4_err_sticky", 32'(err), 32'd1);
    checkOrder("t4", 2);
    if (gaps.size() > 1) checkOutput("t4_gap", 32'(gaps[1]), 32'(GAP + 1));

    // mode change while a word is in flight
    clearHist();
    core_delay = 2; core_hold = 30;
    applyStimulus($urandom, 2'b10);
    k = 0;
    while (rise_ctrl.size() == 0 && k < 100) begin tick(); k++; end
    mode = 2'b11;
    for (int i = 0; i < 5; i++) tick();
    checkOutput("t5_ctrl_inflight", spi_control, 32'h5);
    applyStimulus($urandom, 2'b11);
    drainRx("t5", 2);
    checkOutput("t5_rises", 32'(rise_ctrl.size()), 32'd2);
    if (rise_ctrl.size() >= 2) begin
      checkOutput("t5_ctrl_first", rise_ctrl[0], 32'h5);
      checkOutput("t5_ctrl_second", rise_ctrl[1], 32'h7);
    end

    // reset while waiting for the core to finish
    checkOutput("t6_err_before", 32'(err), 32'd1);
    clearHist();
    core_delay = 2; core_hold = 40;
    applyStimulus($urandom, 2'b01);
    waitRx(300, ok);
    applyStimulus($urandom, 2'b01);
    applyStimulus($urandom, 2'b01);
    k = 0;
    while (!spi_status[0] && k < 300) begin tick(); k++; end
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_rx.delete();
    checkOutput("t6_control", spi_control, 32'd0);
    checkOutput("t6_datain", spi_datain, 32'd0);
    checkOutput("t6_tx_level", 32'(tx_level), 32'd0);
    checkOutput("t6_rx_level", 32'(rx_level), 32'd0);
    checkOutput("t6_rx_valid", 32'(rx_valid), 32'd0);
    checkOutput("t6_rx_data", rx_data, 32'd0);
    checkOutput("t6_err", 32'(err), 32'd0);
    checkOutput("t6_tx_ready", 32'(tx_ready), 32'd1);
    for (int i = 0; i < 60; i++) tick();
    checkOutput("t6_late_fall_rx", 32'(rx_level), 32'd0);
    checkOutput("t6_late_fall_en", 32'(spi_control[0]), 32'd0);
    w = $urandom;
    applyStimulus(w, 2'b10);
    tick();
    tick();
    checkOutput("t6_restart_ctrl", spi_control, 32'h5);
    checkOutput("t6_restart_datain", spi_datain, w);
    drainRx("t6", 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
